// File: rtl/spr_lrctr_file_pkg.sv
// Shared select codes and helpers for the LR/CTR architected register file.
// The width defaults match the LR/CTR width of the core.
package spr_lrctr_file_pkg;

  localparam int SPR_DATA_WIDTH = 32;
  localparam int SPR_SEL_WIDTH  = 2;

  typedef enum logic [SPR_SEL_WIDTH-1:0] {
    SPR_SEL_NONE = 2'b00,
    SPR_SEL_LR   = 2'b01,
    SPR_SEL_CTR  = 2'b10,
    SPR_SEL_RSVD = 2'b11
  } spr_sel_e;

  // The two unused codes are neither LR nor CTR, so they never write or conflict.
  function automatic logic mt_hits(input logic we, input logic [SPR_SEL_WIDTH-1:0] sel,
                                   input spr_sel_e tgt);
    return we & (sel == tgt);
  endfunction

endpackage

// File: rtl/spr_lrctr_file_pend_slot.sv
// One-entry pending (M-stage) slot for a single SPR: a valid bit plus data.
// Flush wins over capture; when capture is off (stall) the slot holds.
module spr_lrctr_file_pend_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cap,
  input  logic                  i_flush,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wd,
  output logic                  o_v,
  output logic [DATA_WIDTH-1:0] o_d
);

  logic                  r_v;
  logic [DATA_WIDTH-1:0] r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (i_cap) begin
      r_v <= i_we;
      if (i_we) r_d <= i_wd;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/spr_lrctr_file.sv
// Architected LR/CTR register file: branch and mtspr writes pass through a one-entry
// pending stage before committing; reads forward the pending value when it exists.
module spr_lrctr_file
  import spr_lrctr_file_pkg::*;
#(
  parameter int                    DATA_WIDTH = SPR_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] LR_RST     = '0,
  parameter logic [DATA_WIDTH-1:0] CTR_RST    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_lr_we,
  input  logic [DATA_WIDTH-1:0]    i_lr_wd,
  input  logic                     i_ctr_we,
  input  logic [DATA_WIDTH-1:0]    i_ctr_wd,
  input  logic                     i_mt_we,
  input  logic [SPR_SEL_WIDTH-1:0] i_mt_sel,
  input  logic [DATA_WIDTH-1:0]    i_mt_wd,
  output logic [DATA_WIDTH-1:0]    o_lr_rd,
  output logic [DATA_WIDTH-1:0]    o_ctr_rd,
  output logic                     o_pend_v,
  output logic                     o_mt_cflt
);

  logic                  w_cap;
  logic                  w_mt_lr;
  logic                  w_mt_ctr;
  logic                  w_lr_we;
  logic                  w_ctr_we;
  logic [DATA_WIDTH-1:0] w_lr_wd;
  logic [DATA_WIDTH-1:0] w_ctr_wd;
  logic                  w_plr_v;
  logic                  w_pctr_v;
  logic [DATA_WIDTH-1:0] w_plr_d;
  logic [DATA_WIDTH-1:0] w_pctr_d;

  logic [DATA_WIDTH-1:0] r_lr_q;
  logic [DATA_WIDTH-1:0] r_ctr_q;
  logic                  r_mt_cflt;

  assign w_cap    = ~i_stall & ~i_flush;
  assign w_mt_lr  = mt_hits(i_mt_we, i_mt_sel, SPR_SEL_LR);
  assign w_mt_ctr = mt_hits(i_mt_we, i_mt_sel, SPR_SEL_CTR);

  // On a same-SPR collision the branch data is the one kept.
  assign w_lr_we  = i_lr_we  | w_mt_lr;
  assign w_ctr_we = i_ctr_we | w_mt_ctr;
  assign w_lr_wd  = i_lr_we  ? i_lr_wd  : i_mt_wd;
  assign w_ctr_wd = i_ctr_we ? i_ctr_wd : i_mt_wd;

  spr_lrctr_file_pend_slot #(.DATA_WIDTH(DATA_WIDTH)) u_pend_lr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cap   (w_cap),
    .i_flush (i_flush),
    .i_we    (w_lr_we),
    .i_wd    (w_lr_wd),
    .o_v     (w_plr_v),
    .o_d     (w_plr_d)
  );

  spr_lrctr_file_pend_slot #(.DATA_WIDTH(DATA_WIDTH)) u_pend_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cap   (w_cap),
    .i_flush (i_flush),
    .i_we    (w_ctr_we),
    .i_wd    (w_ctr_wd),
    .o_v     (w_pctr_v),
    .o_d     (w_pctr_d)
  );

  // Commit shares the capture edge so back-to-back writes sustain one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lr_q    <= LR_RST;
      r_ctr_q   <= CTR_RST;
      r_mt_cflt <= 1'b0;
    end else begin
      if (w_cap && w_plr_v)  r_lr_q  <= w_plr_d;
      if (w_cap && w_pctr_v) r_ctr_q <= w_pctr_d;
      r_mt_cflt <= w_cap & ((i_lr_we & w_mt_lr) | (i_ctr_we & w_mt_ctr));
    end
  end

  assign o_lr_rd   = w_plr_v  ? w_plr_d  : r_lr_q;
  assign o_ctr_rd  = w_pctr_v ? w_pctr_d : r_ctr_q;
  assign o_pend_v  = w_plr_v | w_pctr_v;
  assign o_mt_cflt = r_mt_cflt;

endmodule

// File: tb/tb_spr_lrctr_file.sv
// Directed and random stimulus for spr_lrctr_file against a queue-based reference model.
module tb_spr_lrctr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        lr_we = 1'b0, ctr_we = 1'b0, mt_we = 1'b0;
  logic [31:0] lr_wd = '0, ctr_wd = '0, mt_wd = '0;
  logic [1:0]  mt_sel = 2'b00;
  logic [31:0] lr_rd, ctr_rd;
  logic        pend_v, mt_cflt;

  int total = 0;
  int bad   = 0;

  // Reference model: architected values plus a queue of not-yet-committed writes per SPR.
  logic [31:0] m_lr = '0, m_ctr = '0;
  logic [31:0] q_lr[$];
  logic [31:0] q_ctr[$];
  logic        m_cflt = 1'b0;

  always #5 clk = ~clk;

  spr_lrctr_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_stall   (stall),
    .i_flush   (flush),
    .i_lr_we   (lr_we),
    .i_lr_wd   (lr_wd),
    .i_ctr_we  (ctr_we),
    .i_ctr_wd  (ctr_wd),
    .i_mt_we   (mt_we),
    .i_mt_sel  (mt_sel),
    .i_mt_wd   (mt_wd),
    .o_lr_rd   (lr_rd),
    .o_ctr_rd  (ctr_rd),
    .o_pend_v  (pend_v),
    .o_mt_cflt (mt_cflt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] e_lr, e_ctr;
    e_lr  = (q_lr.size()  != 0) ? q_lr[0]  : m_lr;
    e_ctr = (q_ctr.size() != 0) ? q_ctr[0] : m_ctr;
    chk({tag, ".lr_rd"},   lr_rd,   e_lr);
    chk({tag, ".ctr_rd"},  ctr_rd,  e_ctr);
    chk({tag, ".pend_v"},  {31'd0, pend_v},  {31'd0, (q_lr.size() != 0) || (q_ctr.size() != 0)});
    chk({tag, ".mt_cflt"}, {31'd0, mt_cflt}, {31'd0, m_cflt});
  endtask

  task automatic model_reset();
    m_lr = '0;
    m_ctr = '0;
    q_lr.delete();
    q_ctr.delete();
    m_cflt = 1'b0;
  endtask

  task automatic model_edge();
    bit mlr, mctr;
    if (!rst_n) return;
    mlr  = mt_we && (mt_sel == 2'b01);
    mctr = mt_we && (mt_sel == 2'b10);
    if (flush) begin
      q_lr.delete();
      q_ctr.delete();
      m_cflt = 1'b0;
    end else if (stall) begin
      m_cflt = 1'b0;
    end else begin
      if (q_lr.size()  != 0) m_lr  = q_lr.pop_front();
      if (q_ctr.size() != 0) m_ctr = q_ctr.pop_front();
      if (lr_we)       q_lr.push_back(lr_wd);
      else if (mlr)    q_lr.push_back(mt_wd);
      if (ctr_we)      q_ctr.push_back(ctr_wd);
      else if (mctr)   q_ctr.push_back(mt_wd);
      m_cflt = (lr_we && mlr) || (ctr_we && mctr);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic idle();
    stall = 0; flush = 0; lr_we = 0; ctr_we = 0; mt_we = 0; mt_sel = 2'b00;
  endtask

  initial begin
    // 1: reset, idle, release mid-cycle
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_all("rst_rel");
    tick("idle0");
    tick("idle1");

    // 2: single LR write
    lr_we = 1; lr_wd = 32'h1004;
    tick("lr_n1");
    chk("lr_n1.const", lr_rd, 32'h1004);
    idle();
    tick("lr_n2");
    chk("lr_n2.const", {31'd0, pend_v}, 32'd0);

    // 3: CTR countdown 5,4,3,2
    for (int v = 5; v >= 2; v--) begin
      ctr_we = 1; ctr_wd = 32'(v);
      tick("ctr_seq");
    end
    idle();
    tick("ctr_seq_end");
    chk("ctr_final", ctr_rd, 32'd2);

    // 4: collision on CTR, branch data wins
    ctr_we = 1; ctr_wd = 32'd7; mt_we = 1; mt_sel = 2'b10; mt_wd = 32'd9;
    tick("cflt");
    chk("cflt.ctr", ctr_rd, 32'd7);
    chk("cflt.pulse", {31'd0, mt_cflt}, 32'd1);
    idle();
    tick("cflt_after");

    // reserved select codes do nothing
    mt_we = 1; mt_sel = 2'b11; mt_wd = 32'hDEAD;
    tick("sel11");
    mt_sel = 2'b00;
    tick("sel00");
    idle();

    // 5: write LR then flush with another LR write
    lr_we = 1; lr_wd = 32'h2000;
    tick("fl_w");
    flush = 1; lr_wd = 32'h3000;
    tick("fl_f");
    chk("fl_revert", lr_rd, 32'h1004);
    idle();
    tick("fl_after");
    chk("fl_arch", lr_rd, 32'h1004);

    // 6: CTR write held by stall, then commit; reset during stall
    ctr_we = 1; ctr_wd = 32'h10;
    tick("st_w");
    idle();
    stall = 1;
    ctr_we = 1; ctr_wd = 32'h55;
    repeat (3) tick("st_hold");
    chk("st_hold.const", ctr_rd, 32'h10);
    idle();
    tick("st_commit");
    chk("st_commit.pend", {31'd0, pend_v}, 32'd0);
    ctr_we = 1; ctr_wd = 32'h20;
    tick("st_w2");
    idle();
    stall = 1;
    tick("st_hold2");
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all("st_rst");
    chk("st_rst.const", ctr_rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    tick("post_rst");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 15) == 0);
      lr_we  = $urandom_range(0, 1) == 1;
      ctr_we = $urandom_range(0, 1) == 1;
      mt_we  = $urandom_range(0, 1) == 1;
      mt_sel = 2'($urandom_range(0, 3));
      lr_wd  = $urandom;
      ctr_wd = $urandom;
      mt_wd  = $urandom;
      tick("rand");
    end
    idle();
    tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
